// File: rtl/unum4_div_radix.sv
// Multi-cycle restoring integer divider (signed/unsigned) retiring BITS_PER_CYCLE quotient bits per cycle.
// Optional divide-by-zero / overflow flag outputs enabled by defining UNUM4_DIV_EXC_FLAG_EN.
module unum4_div_radix #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
`ifdef UNUM4_DIV_EXC_FLAG_EN
  ,
  output logic              out_dbz,
  output logic              out_ovf
`endif
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic              r_dvd_neg;
  logic              r_dvs_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_quotient;
  logic [DATA_W-1:0] r_remainder;

  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;
  logic [DATA_W:0]   w_trial;
  logic              w_accept;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ABS;
      S_ABS:   w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Cascade of restoring steps. The trial is one bit wider than the operands:
  // since rem < divisor, its MSB is set exactly when the subtraction borrows.
  // NOTE: blocking assignments here are intentional -- each loop pass must see
  // the previous pass's result within the same combinational evaluation.
  always_comb begin
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    w_trial   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      w_trial = {w_rem_nxt, w_quo_nxt[DATA_W-1]} - {1'b0, r_dvs};
      if (w_trial[DATA_W]) w_rem_nxt = {w_rem_nxt[DATA_W-2:0], w_quo_nxt[DATA_W-1]};
      else                 w_rem_nxt = w_trial[DATA_W-1:0];
      w_quo_nxt = {w_quo_nxt[DATA_W-2:0], ~w_trial[DATA_W]};
    end
  end

  // r_dvd keeps the raw dividend for the whole operation: the divide-by-zero
  // result returns it unchanged and the overflow check compares against it.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvd_neg   <= 1'b0;
      r_dvs_neg   <= 1'b0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd     <= dividend;
            r_dvs     <= divisor;
            r_dvd_neg <= sign & dividend[DATA_W-1];
            r_dvs_neg <= sign & divisor[DATA_W-1];
          end
        end
        S_ABS: begin
          r_quo <= r_dvd_neg ? -r_dvd : r_dvd;
          r_dvs <= r_dvs_neg ? -r_dvs : r_dvs;
          r_rem <= '0;
          r_cnt <= CNT_W'(N - 1);
        end
        S_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (r_dvs == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd;
          end else begin
            r_quotient  <= (r_dvd_neg ^ r_dvs_neg) ? -r_quo : r_quo;
            r_remainder <= r_dvd_neg ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UNUM4_DIV_EXC_FLAG_EN
  logic r_sign;
  logic r_dbz;
  logic r_ovf;

  assign out_dbz = r_dbz;
  assign out_ovf = r_ovf;

  // At FIX r_dvs holds the divisor magnitude, so magnitude 1 with a negative
  // sign identifies an original divisor of -1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_sign <= sign;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_dbz <= (r_dvs == '0);
      r_ovf <= r_sign && (r_dvd == {1'b1, {(DATA_W-1){1'b0}}})
               && r_dvs_neg && (r_dvs == DATA_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_unum4_div_radix.sv
// Directed self-checking bench for unum4_div_radix: three instances with BITS_PER_CYCLE 1, 2 and 4.
// Flag outputs are checked only when UNUM4_DIV_EXC_FLAG_EN is defined.
module tb_unum4_div_radix;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [31:0] quo [3];
  logic [31:0] rem [3];
`ifdef UNUM4_DIV_EXC_FLAG_EN
  logic [2:0]  dbz;
  logic [2:0]  ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  unum4_div_radix #(.DATA_W(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sign(sign),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid[0]), .out_ready(out_ready),
    .quotient(quo[0]), .remainder(rem[0])
`ifdef UNUM4_DIV_EXC_FLAG_EN
    , .out_dbz(dbz[0]), .out_ovf(ovf[0])
`endif
  );

  unum4_div_radix #(.DATA_W(32), .BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sign(sign),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid[1]), .out_ready(out_ready),
    .quotient(quo[1]), .remainder(rem[1])
`ifdef UNUM4_DIV_EXC_FLAG_EN
    , .out_dbz(dbz[1]), .out_ovf(ovf[1])
`endif
  );

  unum4_div_radix #(.DATA_W(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .sign(sign),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid[2]), .out_ready(out_ready),
    .quotient(quo[2]), .remainder(rem[2])
`ifdef UNUM4_DIV_EXC_FLAG_EN
    , .out_dbz(dbz[2]), .out_ovf(ovf[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One division on instance idx; optionally holds out_ready low for five
  // cycles while presenting a conflicting request that must be ignored.
  task automatic divide(input int idx, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dbz, input logic exp_ovf, input int exp_lat,
                        input bit stall, input string tag);
    int lat;
    @(negedge clk);
    sign          = sgn;
    dividend      = a;
    divisor       = b;
    in_valid[idx] = 1'b1;
    chk({tag, "/ready_idle"}, 32'(in_ready[idx]), 32'd1);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    dividend      = 32'hA5A5_A5A5;
    divisor       = 32'h0000_0001;
    sign          = ~sgn;
    chk({tag, "/ready_busy"}, 32'(in_ready[idx]), 32'd0);
    while (!out_valid[idx] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/quotient"}, quo[idx], exp_q);
    chk({tag, "/remainder"}, rem[idx], exp_r);
`ifdef UNUM4_DIV_EXC_FLAG_EN
    chk({tag, "/dbz"}, 32'(dbz[idx]), 32'(exp_dbz));
    chk({tag, "/ovf"}, 32'(ovf[idx]), 32'(exp_ovf));
`else
    if (exp_dbz || exp_ovf) vectors = vectors + 0;
`endif
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        in_valid[idx] = 1'b1;
        dividend      = 32'h0000_0009;
        divisor       = 32'h0000_0003;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/stall_valid"}, 32'(out_valid[idx]), 32'd1);
        chk({tag, "/stall_ready"}, 32'(in_ready[idx]), 32'd0);
        chk({tag, "/stall_q"}, quo[idx], exp_q);
        chk({tag, "/stall_r"}, rem[idx], exp_r);
      end
      in_valid[idx] = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/valid_drop"}, 32'(out_valid[idx]), 32'd0);
    chk({tag, "/ready_back"}, 32'(in_ready[idx]), 32'd1);
    chk({tag, "/q_held"}, quo[idx], exp_q);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = '0;
    sign      = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/in_ready", 32'(in_ready), 32'b111);
    chk("reset/out_valid", 32'(out_valid), 32'b000);
    chk("reset/quotient", quo[0], 32'h0);
    chk("reset/remainder", rem[0], 32'h0);
`ifdef UNUM4_DIV_EXC_FLAG_EN
    chk("reset/flags", 32'({dbz, ovf}), 32'h0);
`endif
    rst = 1'b0;

    divide(0, 1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 34, 1'b0, "u100_7");
    divide(0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 34, 1'b0, "s-100_7");
    divide(0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 34, 1'b0, "s100_-7");
    divide(2, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 10, 1'b0, "s-100_-7_b4");
    divide(0, 1'b1, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 34, 1'b0, "s_dbz");
    divide(0, 1'b0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 34, 1'b0, "u_dbz");
    divide(2, 1'b1, 32'h87654321, 32'h0,        32'hFFFFFFFF, 32'h87654321, 1'b1, 1'b0, 10, 1'b0, "s_dbz_neg_b4");
    divide(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b1, 34, 1'b0, "s_ovf");
    divide(0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0, 34, 1'b0, "u_min_max");
    divide(1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 18, 1'b1, "stall_b2");

    // Abort a running division on the BPC=1 instance with reset.
    @(negedge clk);
    sign        = 1'b0;
    dividend    = 32'd100;
    divisor     = 32'd7;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort/in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort/out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort/quotient", quo[0], 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("abort/no_result", 32'(seen), 32'd0);

    divide(1, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'h0, 1'b0, 1'b0, 18, 1'b0, "u_max_3_b2");
    divide(2, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'h0, 1'b0, 1'b0, 10, 1'b0, "u_max_3_b4");
    divide(0, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'h0, 1'b0, 1'b0, 34, 1'b0, "u_max_3_b1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
